// File: rtl/hrg_pkg.sv
// Shared types and geometry for the nibble-memory raster scan-out engine.
package hrg_pkg;

  localparam int unsigned ADDR_W = 15;
  localparam int unsigned NIB_W  = 4;

  localparam int unsigned H_NIBBLES_DEF  = 128;
  localparam int unsigned V_LINES_DEF    = 160;
  localparam int unsigned ADDR_LIMIT_DEF = 20480;
  localparam int unsigned BASE_ADDR_DEF  = 0;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  typedef enum logic [0:0] {
    StIdle,
    StActive
  } hrg_state_e;

  // Next nibble address, wrapping at the memory depth.
  function automatic logic [ADDR_W-1:0] addr_inc(input logic [ADDR_W-1:0] addr,
                                                 input int unsigned limit);
    if (32'(addr) == limit - 1) return '0;
    return addr + 1'b1;
  endfunction

endpackage

// File: rtl/hrg_nibble_scanout_if.sv
// Read-only port B of the video nibble RAM as seen by the scan-out engine.
interface hrg_nibble_scanout_if;
  import hrg_pkg::*;

  logic [ADDR_W-1:0] adb;
  logic              ceb;
  logic              oceb;
  logic              wreb;
  logic [NIB_W-1:0]  doutb;

  modport master (output adb, output ceb, output oceb, output wreb, input doutb);
  modport slave  (input adb, input ceb, input oceb, input wreb, output doutb);
endinterface

// File: rtl/hrg_prefetch_fifo.sv
// Small synchronous show-ahead FIFO with occupancy count; depth must be a power of 2.
module hrg_prefetch_fifo #(
  parameter int unsigned Width = 4,
  parameter int unsigned Depth = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear_i,
  input  logic                         push_i,
  input  logic [Width-1:0]             wdata_i,
  input  logic                         pop_i,
  output logic [Width-1:0]             rdata_o,
  output logic [$clog2(Depth+1)-1:0]   count_o
);
  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  wptr_q, rptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  assign do_push = push_i && (count_q != CntW'(Depth));
  assign do_pop  = pop_i && (count_q != '0);
  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

  always_ff @(posedge clk) begin
    if (do_push && !clear_i) mem_q[wptr_q] <= wdata_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
    end
  end
endmodule

// File: rtl/hrg_nibble_scanout.sv
// Raster scan-out: fetches nibbles over RAM port B and shifts them out MSB-first,
// one pixel per pix_en, hiding the 2-cycle read latency behind a prefetch FIFO.
module hrg_nibble_scanout
  import hrg_pkg::*;
#(
  parameter int unsigned H_NIBBLES  = H_NIBBLES_DEF,
  parameter int unsigned V_LINES    = V_LINES_DEF,
  parameter int unsigned ADDR_LIMIT = ADDR_LIMIT_DEF,
  parameter int unsigned BASE_ADDR  = BASE_ADDR_DEF,
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 frame_start,
  input  logic                 line_start,
  input  logic                 pix_en,
  hrg_nibble_scanout_if.master ram,
  output logic                 pixel,
  output logic                 pixel_valid,
  output logic                 line_active,
  output logic                 underrun
);
  localparam int unsigned IssW    = $clog2(H_NIBBLES + 1);
  localparam int unsigned LinePix = 4 * H_NIBBLES;
  localparam int unsigned PixW    = $clog2(LinePix + 1);
  localparam int unsigned CntW    = $clog2(FIFO_DEPTH + 1);

  if (FIFO_DEPTH < 3 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of 2 and at least 3");
  end
  if (H_NIBBLES * V_LINES > ADDR_LIMIT || ADDR_LIMIT > (1 << ADDR_W) ||
      BASE_ADDR >= ADDR_LIMIT) begin : g_bad_geom
    $error("frame geometry does not fit the nibble memory");
  end

  hrg_state_e        state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [IssW-1:0]   issued_q, skip_q;
  logic [PixW-1:0]   pix_cnt_q;
  logic [1:0]        tag_q;
  logic [NIB_W-1:0]  shreg_q;
  logic [2:0]        rem_q;

  logic [CntW-1:0]   fifo_count;
  logic [NIB_W-1:0]  fifo_rdata;
  logic [CntW:0]     occupancy;
  logic              issue, consume, need_nib, fifo_pop, fifo_push, starve, drop, last_pix;

  assign occupancy = (CntW+1)'(fifo_count) + (CntW+1)'(tag_q[0]) + (CntW+1)'(tag_q[1]);
  assign issue     = (state_q == StActive) && !line_start &&
                     (issued_q < IssW'(H_NIBBLES)) && (occupancy < (CntW+1)'(FIFO_DEPTH));
  assign consume   = (state_q == StActive) && pix_en && !line_start;
  assign need_nib  = consume && (rem_q == '0);
  assign fifo_pop  = need_nib && (fifo_count != '0);
  assign starve    = need_nib && (fifo_count == '0);
  // Each starved nibble slot owes one late return, which must be thrown away.
  assign drop      = tag_q[1] && (skip_q != '0);
  assign fifo_push = tag_q[1] && (skip_q == '0);
  assign last_pix  = consume && (pix_cnt_q == PixW'(LinePix - 1));

  assign ram.ceb     = issue;
  assign ram.adb     = issue ? addr_q : '0;
  assign ram.oceb    = 1'b1;
  assign ram.wreb    = 1'b0;
  assign line_active = (state_q == StActive);

  hrg_prefetch_fifo #(
    .Width (NIB_W),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear_i (line_start),
    .push_i  (fifo_push),
    .wdata_i (ram.doutb),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      addr_q      <= ADDR_W'(BASE_ADDR);
      issued_q    <= '0;
      skip_q      <= '0;
      pix_cnt_q   <= '0;
      tag_q       <= '0;
      shreg_q     <= '0;
      rem_q       <= '0;
      pixel       <= 1'b0;
      pixel_valid <= 1'b0;
      underrun    <= 1'b0;
    end else begin
      pixel_valid <= consume;
      if (frame_start)  addr_q <= ADDR_W'(BASE_ADDR);
      else if (issue)   addr_q <= addr_inc(addr_q, ADDR_LIMIT);
      if (starve)           underrun <= 1'b1;
      else if (frame_start) underrun <= 1'b0;

      if (line_start) begin
        state_q   <= StActive;
        issued_q  <= '0;
        skip_q    <= '0;
        pix_cnt_q <= '0;
        tag_q     <= '0;
        shreg_q   <= '0;
        rem_q     <= '0;
      end else begin
        tag_q <= {tag_q[0], issue};
        if (issue) issued_q <= issued_q + 1'b1;
        if (starve && !drop)      skip_q <= skip_q + 1'b1;
        else if (drop && !starve) skip_q <= skip_q - 1'b1;
        if (consume) begin
          pix_cnt_q <= pix_cnt_q + 1'b1;
          if (last_pix) state_q <= StIdle;
          if (rem_q != '0) begin
            pixel   <= shreg_q[NIB_W-1];
            shreg_q <= {shreg_q[NIB_W-2:0], 1'b0};
            rem_q   <= rem_q - 1'b1;
          end else if (fifo_pop) begin
            pixel   <= fifo_rdata[NIB_W-1];
            shreg_q <= {fifo_rdata[NIB_W-2:0], 1'b0};
            rem_q   <= 3'd3;
          end else begin
            // Starved: a whole zero nibble stands in so line alignment is kept.
            pixel   <= 1'b0;
            shreg_q <= '0;
            rem_q   <= 3'd3;
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_hrg_nibble_scanout.sv
// Bench for hrg_nibble_scanout: RAM model returns addr[3:0], pixels checked via a queue.
module tb_hrg_nibble_scanout;
  localparam int unsigned Base2 = 20400;
  localparam int unsigned Limit = 20480;

  logic clk = 1'b0;
  logic reset;
  logic frame_start, line_start, pix_en;
  logic pixel, pixel_valid, line_active, underrun;
  logic pixel2, pixel_valid2, line_active2, underrun2;

  hrg_nibble_scanout_if ram ();
  hrg_nibble_scanout_if ram2 ();

  hrg_nibble_scanout dut (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pix_en      (pix_en),
    .ram         (ram),
    .pixel       (pixel),
    .pixel_valid (pixel_valid),
    .line_active (line_active),
    .underrun    (underrun)
  );

  hrg_nibble_scanout #(.BASE_ADDR(Base2)) dut2 (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .line_start  (line_start),
    .pix_en      (pix_en),
    .ram         (ram2),
    .pixel       (pixel2),
    .pixel_valid (pixel_valid2),
    .line_active (line_active2),
    .underrun    (underrun2)
  );

  always #5 clk = ~clk;

  // Port-B model: data = address low nibble, valid two cycles after ceb.
  logic [3:0] r1, r1b;
  always @(posedge clk) begin
    if (ram.ceb) r1 <= ram.adb[3:0];
    if (ram.oceb) ram.doutb <= r1;
    if (ram2.ceb) r1b <= ram2.adb[3:0];
    if (ram2.oceb) ram2.doutb <= r1b;
  end

  int checks = 0;
  int errors = 0;
  bit exp_q[$];
  int exp_adb, exp_adb2, ceb_cnt, line_max, cnt2, last2;
  bit wrap2;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Address sequence monitors and pixel scoreboard, sampled on the falling edge.
  initial forever begin
    @(negedge clk);
    if (reset) begin
      exp_adb  = 0;
      exp_adb2 = Base2;
      cnt2     = 0;
      wrap2    = 0;
    end else begin
      if (ram.ceb) begin
        check("adb_seq", 32'(ram.adb), exp_adb);
        ceb_cnt++;
        if (int'(ram.adb) > line_max) line_max = int'(ram.adb);
      end
      if (frame_start)  exp_adb = 0;
      else if (ram.ceb) exp_adb = (exp_adb + 1) % Limit;
      if (ram2.ceb) begin
        check("adb2_seq", 32'(ram2.adb), exp_adb2);
        if (ram2.adb == 0 && last2 == Limit - 1) wrap2 = 1;
        last2 = int'(ram2.adb);
        cnt2++;
      end
      if (frame_start) begin
        exp_adb2 = Base2;
        cnt2     = 0;
        wrap2    = 0;
      end else if (ram2.ceb) exp_adb2 = (exp_adb2 + 1) % Limit;
    end
    if (pixel_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pixel_unexpected: actual pixel_valid 1, expected 0");
      end else begin
        check("pixel", 32'(pixel), 32'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: actual timeout, expected finish");
    $fatal(1);
  end

  task automatic run_line(input bit do_frame, input int delay, input int stall_at,
                          input int stall_len, input int npix, input int base,
                          input bit early_zero);
    int p, st, nb;
    step();
    frame_start = do_frame;
    line_start  = 1'b1;
    ceb_cnt     = 0;
    line_max    = 0;
    step();
    frame_start = 1'b0;
    line_start  = 1'b0;
    repeat (delay - 1) step();
    p  = 0;
    st = 0;
    while (p < npix) begin
      if (p == stall_at && st < stall_len) begin
        pix_en = 1'b0;
        st++;
        if (st == stall_len) check("stall_ceb_idle", 32'(ram.ceb), 0);
      end else begin
        if (npix == 512 && p == 511) check("line_active_last", 32'(line_active), 1);
        pix_en = 1'b1;
        nb = base + p / 4;
        exp_q.push_back((early_zero && p < 4) ? 1'b0 : (((nb >> (3 - (p % 4))) & 1) != 0));
        p++;
      end
      step();
    end
    if (npix == 512) check("line_active_end", 32'(line_active), 0);
    pix_en = 1'b0;
  endtask

  typedef struct {
    bit do_frame;
    int delay;
    int stall_at;
    int stall_len;
    int base;
    bit early_zero;
    bit exp_underrun;
    int exp_max_adb;
  } line_vec_t;

  line_vec_t vecs [3];

  initial begin
    vecs[0] = '{1'b1, 4, -1, 0, 0, 1'b0, 1'b0, 127};
    vecs[1] = '{1'b0, 4, 100, 20, 128, 1'b0, 1'b0, 255};
    vecs[2] = '{1'b1, 1, -1, 0, 0, 1'b1, 1'b1, 127};

    reset = 1'b1;
    frame_start = 1'b0;
    line_start  = 1'b0;
    pix_en      = 1'b0;
    repeat (3) step();
    check("rst_adb", 32'(ram.adb), 0);
    check("rst_ceb", 32'(ram.ceb), 0);
    check("rst_oceb", 32'(ram.oceb), 1);
    check("rst_wreb", 32'(ram.wreb), 0);
    check("rst_pixel", 32'(pixel), 0);
    check("rst_pixel_valid", 32'(pixel_valid), 0);
    check("rst_line_active", 32'(line_active), 0);
    check("rst_underrun", 32'(underrun), 0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 3; i++) begin
      run_line(vecs[i].do_frame, vecs[i].delay, vecs[i].stall_at, vecs[i].stall_len, 512,
               vecs[i].base, vecs[i].early_zero);
      step();
      check("vec_underrun", 32'(underrun), 32'(vecs[i].exp_underrun));
      check("vec_ceb_count", ceb_cnt, 128);
      check("vec_max_adb", line_max, vecs[i].exp_max_adb);
      check("vec_queue_drained", exp_q.size(), 0);
      if (i == 0) begin
        check("wrap_count", cnt2, 128);
        check("wrap_last_adb", last2, 47);
        check("wrap_seen", 32'(wrap2), 1);
      end
    end

    frame_start = 1'b1;
    step();
    frame_start = 1'b0;
    check("frame_clears_underrun", 32'(underrun), 0);

    // Six reads (0..5) are issued before the re-pulse; the last is still in flight.
    run_line(1'b1, 4, -1, 0, 6, 0, 1'b0);
    run_line(1'b0, 4, -1, 0, 512, 6, 1'b0);
    step();
    check("restart_ceb_count", ceb_cnt, 128);
    check("restart_max_adb", line_max, 133);
    check("restart_underrun", 32'(underrun), 0);
    check("restart_queue_drained", exp_q.size(), 0);

    run_line(1'b1, 1, -1, 0, 3, 0, 1'b1);
    check("midline_active", 32'(line_active), 1);
    check("midline_underrun", 32'(underrun), 1);
    #2;
    reset = 1'b1;
    #1;
    check("async_adb", 32'(ram.adb), 0);
    check("async_ceb", 32'(ram.ceb), 0);
    check("async_oceb", 32'(ram.oceb), 1);
    check("async_wreb", 32'(ram.wreb), 0);
    check("async_pixel", 32'(pixel), 0);
    check("async_pixel_valid", 32'(pixel_valid), 0);
    check("async_line_active", 32'(line_active), 0);
    check("async_underrun", 32'(underrun), 0);
    exp_q.delete();
    step();
    step();
    reset = 1'b0;

    repeat (5) begin
      pix_en = 1'b1;
      step();
      check("idle_pixel_valid", 32'(pixel_valid), 0);
      check("idle_underrun", 32'(underrun), 0);
      check("idle_ceb", 32'(ram.ceb), 0);
    end
    pix_en = 1'b0;
    step();
    check("final_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
